// File: rtl/expr_emitter.sv
// Emits an arithmetic expression (BCD operands joined by "+"/"*") as a handshaked ASCII stream.
// Define EXPR_TERM_EN to append a handshaked "=" terminator after the final operand.
module expr_emitter (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [3:0]  len,
    input  logic [31:0] digits,
    input  logic [6:0]  ops,
    input  logic        ready,
    output logic [7:0]  out,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);

`ifdef EXPR_TERM_EN
    typedef enum logic [2:0] {IDLE, DIGIT, OP, FIN, TERM} state_t;
`else
    typedef enum logic [2:0] {IDLE, DIGIT, OP, FIN} state_t;
`endif

    // Handshake: a character moves when valid and ready are both high at a rising
    // edge; out/valid hold their values until that happens.
    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  len_q, len_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  ops_q, ops_d;
    logic [7:0]  out_q, out_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        bad_operand;
    logic        last_operand;
    logic [2:0]  idx_next;
    logic [3:0]  next_digit;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        digits_d    = digits_q;
        ops_d       = ops_q;
        out_d       = out_q;
        valid_d     = valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        bad_operand = 1'b0;

        // Only operands that will actually be emitted must be valid BCD.
        for (int k = 0; k < 8; k++) begin
            if ((4'(k) < len) && (digits[4*k +: 4] > 4'd9)) begin
                bad_operand = 1'b1;
            end
        end

        last_operand = ({1'b0, idx_q} == (len_q - 4'd1));
        idx_next     = idx_q + 3'd1;
        next_digit   = digits_q[{idx_next, 2'b00} +: 4];

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    if ((len == 4'd0) || (len > 4'd8) || bad_operand) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = DIGIT;
                        idx_d    = 3'd0;
                        len_d    = len;
                        digits_d = digits;
                        ops_d    = {1'b0, ops};
                        out_d    = 8'h30 + {4'h0, digits[3:0]};
                        valid_d  = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
            end
            DIGIT: begin
                if (ready) begin
                    if (last_operand) begin
`ifdef EXPR_TERM_EN
                        state_d = TERM;
                        out_d   = 8'h3D;
`else
                        state_d = FIN;
                        out_d   = 8'h00;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = OP;
                        out_d   = ops_q[idx_q] ? 8'h2A : 8'h2B;
                    end
                end
            end
            OP: begin
                if (ready) begin
                    state_d = DIGIT;
                    idx_d   = idx_next;
                    out_d   = 8'h30 + {4'h0, next_digit};
                end
            end
`ifdef EXPR_TERM_EN
            TERM: begin
                if (ready) begin
                    state_d = FIN;
                    out_d   = 8'h00;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            len_q    <= 4'd0;
            digits_q <= 32'd0;
            ops_q    <= 8'd0;
            out_q    <= 8'h00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            digits_q <= digits_d;
            ops_q    <= ops_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign out       = out_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_expr_emitter.sv
// Self-checking bench for expr_emitter: expected characters are queued when a start
// is driven and popped on every observed transfer.
module tb_expr_emitter;

    logic        clk;
    logic        clr;
    logic        start;
    logic [3:0]  len;
    logic [31:0] digits;
    logic [6:0]  ops;
    logic        ready;
    logic [7:0]  out;
    logic        valid;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    int vectors;
    int miscompares;
    logic [7:0] exp_q[$];

    expr_emitter dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .len       (len),
        .digits    (digits),
        .ops       (ops),
        .ready     (ready),
        .out       (out),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: digit, operator, digit ... (+ "=" when the terminator is built in)
    task automatic push_model(input logic [3:0] l, input logic [31:0] d, input logic [6:0] o);
        logic [3:0] nib;
        for (int k = 0; k < int'(l); k++) begin
            nib = 4'((d >> (4 * k)) & 32'hF);
            exp_q.push_back(8'h30 + {4'h0, nib});
            if (k < int'(l) - 1) exp_q.push_back(o[k] ? 8'h2A : 8'h2B);
        end
`ifdef EXPR_TERM_EN
        exp_q.push_back(8'h3D);
`endif
    endtask

    // driver: one-cycle start pulse, returns at the negedge after the accepting edge
    task automatic do_start(input logic [3:0] l, input logic [31:0] d, input logic [6:0] o);
        @(negedge clk);
        len    = l;
        digits = d;
        ops    = o;
        start  = 1'b1;
        push_model(l, d, o);
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready
    task automatic drain(input int mode, input int budget);
        int         c;
        logic       prev_stall;
        logic [7:0] prev_out;
        logic [7:0] e;
        c = 0;
        prev_stall = 1'b0;
        prev_out = 8'h00;
        vectors++;
        if (valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL first_char: valid=%b busy=%b required valid=1 busy=1", valid, busy);
        end
        forever begin
            case (mode)
                0: ready = 1'b1;
                1: ready = ((c % 3) == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (prev_stall) begin
                vectors++;
                if (valid !== 1'b1 || out !== prev_out) begin
                    miscompares++;
                    $display("FAIL stall_hold: valid=%b out=%h required valid=1 out=%h", valid, out, prev_out);
                end
            end
            if (valid && ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_char: out=%h required no transfer", out);
                end else begin
                    e = exp_q.pop_front();
                    if (out !== e) begin
                        miscompares++;
                        $display("FAIL char: out=%h required %h", out, e);
                    end
                end
                if (exp_q.size() == 0) begin
                    @(negedge clk);
                    #1;
                    vectors++;
                    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
                        miscompares++;
                        $display("FAIL done_pulse: done=%b valid=%b busy=%b required 1 0 0", done, valid, busy);
                    end
                    @(negedge clk);
                    #1;
                    vectors++;
                    if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
                        miscompares++;
                        $display("FAIL done_end: done=%b valid=%b busy=%b required 0 0 0", done, valid, busy);
                    end
                    ready = 1'b0;
                    return;
                end
            end else if (valid !== 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL bubble: valid=%b required 1 with %0d chars pending", valid, exp_q.size());
            end
            prev_stall = valid && !ready;
            prev_out = out;
            c++;
            if (c > budget) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout: %0d chars pending required 0", exp_q.size());
                exp_q.delete();
                ready = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        #1;
        vectors++;
        if (out !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || dbg_state !== 3'd0) begin
            miscompares++;
            $display("FAIL reset: out=%h valid=%b busy=%b done=%b err=%b state=%0d required all 0",
                     out, valid, busy, done, err, dbg_state);
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_basic();
        do_start(4'd3, 32'h0000_0725, 7'b0000010);
        drain(0, 50);
    endtask

    task automatic test_stall();
        do_start(4'd3, 32'h0000_0725, 7'b0000010);
        drain(1, 80);
    endtask

    task automatic test_single();
        do_start(4'd1, 32'hFFFF_FFF9, 7'b1111111);
        drain(0, 20);
        do_start(4'd8, 32'h9999_9999, 7'b1010101);
        drain(0, 60);
    endtask

    task automatic check_reject(input logic [3:0] l, input logic [31:0] d);
        @(negedge clk);
        len    = l;
        digits = d;
        ops    = 7'd0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reject_pulse len=%0d: err=%b valid=%b busy=%b required 1 0 0", l, err, valid, busy);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (err !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reject_after len=%0d: err=%b valid=%b busy=%b required 0 0 0", l, err, valid, busy);
        end
    endtask

    task automatic test_reject();
        check_reject(4'd0, 32'h0000_0001);
        check_reject(4'd9, 32'h1111_1111);
        check_reject(4'd2, 32'h0000_00A1);
    endtask

    task automatic test_clear();
        do_start(4'd3, 32'h0000_0725, 7'b0000010);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        vectors++;
        if (out !== 8'h2B || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_clear: out=%h valid=%b required 2b 1", out, valid);
        end
        #1 clr = 1'b1;
        #1;
        vectors++;
        if (out !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 3'd0) begin
            miscompares++;
            $display("FAIL async_clear: out=%h valid=%b busy=%b state=%0d required 00 0 0 0",
                     out, valid, busy, dbg_state);
        end
        #1 clr = 1'b0;
        exp_q.delete();
        do_start(4'd2, 32'h0000_0031, 7'b0000000);
        drain(0, 30);
    endtask

    task automatic test_busy_start();
        do_start(4'd3, 32'h0000_0468, 7'b0000001);
        ready  = 1'b0;
        start  = 1'b1;
        len    = 4'd2;
        digits = 32'h0000_0011;
        ops    = 7'b1111111;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start_err: err=%b required 0", err);
        end
        drain(0, 40);
    endtask

    task automatic test_random();
        logic [3:0]  l;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            l = 4'($urandom_range(1, 8));
            for (int k = 0; k < 8; k++) d[4*k +: 4] = 4'($urandom_range(0, 9));
            do_start(l, d, 7'($urandom));
            drain(2, 200);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        start  = 1'b0;
        len    = 4'd0;
        digits = 32'd0;
        ops    = 7'd0;
        ready  = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_single();
        test_reject();
        test_clear();
        test_busy_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/expr_emitter.md
EXPR_EMITTER -- requirements
Module: expr_emitter

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, rising-edge.
REQ-002 SHALL have ports: clr  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: start  input  1  request to emit one expression; sampled only in IDLE.
REQ-004 SHALL have ports: len  input  4  operand count; legal range 1..8.
REQ-005 SHALL have ports: digits  input  32  8 BCD operands; operand k = digits[4k+3:4k], operand 0 emitted first.
REQ-006 SHALL have ports: ops  input  7  operator k sits between operand k and k+1; 0 = "+" (0x2B), 1 = "*" (0x2A).
REQ-007 SHALL have ports: ready  input  1  downstream accepts the current character.
REQ-008 SHALL have ports: out  output  8  ASCII character.
REQ-009 SHALL have ports: valid  output  1  out holds a character.
REQ-010 SHALL have ports: busy  output  1  an expression is in progress.
REQ-011 SHALL have ports: done  output  1  one-cycle pulse after the final transfer.
REQ-012 SHALL have ports: err  output  1  one-cycle pulse on a rejected start.

Function
REQ-013 SHALL use states IDLE, DIGIT, OP, FIN; state and all outputs are registered.
REQ-014 SHALL latch len, digits and ops when it accepts a start in IDLE; later input changes do not affect the expression in flight.
REQ-015 SHALL reject a start whose len is 0 or greater than 8: err=1 for 1 cycle, no characters, state stays IDLE.
REQ-016 SHALL reject a start where any used operand (k < len) is greater than 9: err=1 for 1 cycle, no characters, state stays IDLE.
REQ-017 SHALL, on an accepted start at edge N, drive valid=1, busy=1 and out="0"+operand0 from edge N+1 (state DIGIT).
REQ-018 SHALL define a transfer as valid=1 and ready=1 at a rising edge; out and valid hold stable until that transfer occurs.
REQ-019 SHALL, on a DIGIT transfer of operand k with k < len-1, present operator k on the next cycle (state OP).
REQ-020 SHALL, on an OP transfer, present operand k+1 on the next cycle (state DIGIT); valid stays high, with no bubble between characters.
REQ-021 SHALL, on the final transfer, go to FIN: valid=0, busy=0, done=1 for exactly 1 cycle, then return to IDLE.
REQ-022 SHALL ignore start while in DIGIT, OP or FIN; no err and no effect.
REQ-023 SHALL emit a character sequence that alternates digit, operator, digit, begins and ends with a digit, and always contains len digits and len-1 operators.
REQ-024 SHALL keep a 3-bit operand index that never wraps; index len-1 is the terminal operand.

Reset
REQ-025 SHALL force, on clr=1 at any time (including mid-expression), state=IDLE, index=0, out=8'h00, valid=0, busy=0, done=0, err=0 immediately without waiting for clk.
REQ-026 SHALL, after clr deasserts, accept no start before the first rising clk edge; a partial expression is never resumed.

Configuration
REQ-027 SHALL compile the terminator feature in only when EXPR_TERM_EN is defined.
- EXPR_TERM_EN defined: after the final digit transfer, emit "=" (0x3D) as one extra handshaked character (state TERM); done follows its transfer.
- EXPR_TERM_EN undefined: no TERM state; done follows the final digit transfer.

Verification
REQ-028 SHALL cover: len=3, digits=32'h00000_7_2_5 (op0="+", op1="*"), ops=7'b0000010, ready=1 -> out "5","+","2","*","7" on consecutive cycles; done 1 cycle later (with EXPR_TERM_EN: "=" before done).
REQ-029 SHALL cover: the same stimulus with ready toggling 1,0,0,1,... -> out/valid held through stalls, same 5-character order, no duplicates.
REQ-030 SHALL cover: len=1, digits[3:0]=9 -> single "9" then done; no operator emitted.
REQ-031 SHALL cover: len=0, then len=9, then len=2 with digits[7:4]=4'hA -> err pulse each time, valid never rises, busy stays 0.
REQ-032 SHALL cover: clr pulsed mid-phase while out="+" -> valid=0 and out=0 asynchronously; a new start then emits its operand 0 first.
REQ-033 SHALL cover: start asserted with a different len while busy -> ignored; the original expression completes unchanged.
